// File: rtl/cmp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cmp_pkg                                                   |
// | Purpose  : Shared definitions for the compare-datapath arbiter:     |
// |            funct3 compare codes and the sequencer state encoding.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package cmp_pkg;

  // funct3 compare codes (unsigned unless noted)
  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_LTU = 3'b010;
  localparam logic [2:0] CMP_GEU = 3'b011;
  localparam logic [2:0] CMP_GTU = 3'b100;
  localparam logic [2:0] CMP_LEU = 3'b101;
  localparam logic [2:0] CMP_LT  = 3'b110;  // signed, optional
  localparam logic [2:0] CMP_GE  = 3'b111;  // signed, optional

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    RESP = ST_RESP
  } cmp_state_e;

endpackage
`default_nettype wire

// File: rtl/cmp_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cmp_rr_arb                                                |
// | Purpose  : Combinational 2-way round-robin picker. The pointer       |
// |            register is owned by the caller.                          |
// | Ports    : valid[1:0]  request valid vector                          |
// |            ptr         requester that wins when both are valid       |
// |            en          allow a grant this cycle                      |
// |            grant[1:0]  one-hot (or zero) grant                       |
// |            next_ptr    pointer value to load when a grant is taken   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cmp_rr_arb
  import cmp_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] grant,
  output logic       next_ptr
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) begin
        grant = ptr ? 2'b10 : 2'b01;
      end else begin
        // a lone requester wins regardless of the pointer
        grant = valid;
      end
    end
  end

  // After a grant the pointer moves to the requester that did not win
  always_comb begin
    next_ptr = ptr;
    if (grant[0]) begin
      next_ptr = 1'b1;
    end else if (grant[1]) begin
      next_ptr = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cmp_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cmp_arbiter                                               |
// | Purpose  : Two-requester arbiter/sequencer for the shared compare    |
// |            datapath. Grants round-robin, latches operands, registers |
// |            the comparison, and holds the result until accepted.      |
// | Ports    : clk, rst_n (async, active-low)                            |
// |            req_valid/req_ready[NREQ]   request handshake             |
// |            req_a/req_b[NREQ*WIDTH]     operands, requester i slice i |
// |            req_funct3[NREQ*3]          compare code per requester    |
// |            rsp_valid/rsp_ready[NREQ]   response handshake            |
// |            rsp_flag, rsp_illegal       shared registered result      |
// | Config   : `define CMP_ARB_SIGNED_EN enables signed codes 110/111;   |
// |            otherwise they report rsp_illegal.                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2    // only 2 is supported
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_funct3,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic                  rsp_flag,
  output logic                  rsp_illegal
);

  cmp_state_e       r_state;
  cmp_state_e       w_state_nxt;
  logic             r_ptr;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_f3;
  logic             r_flag;
  logic             r_illegal;

  logic [1:0]       w_grant;
  logic             w_next_ptr;
  logic             w_take;
  logic             w_sel;
  logic             w_flag;
  logic             w_illegal;

  // Grants only in IDLE; rst_n in the enable forces req_ready low during reset
  cmp_rr_arb u_rr_arb (
    .valid    (req_valid),
    .ptr      (r_ptr),
    .en       ((r_state == IDLE) && rst_n),
    .grant    (w_grant),
    .next_ptr (w_next_ptr)
  );

  assign req_ready = w_grant;
  // grant is always a subset of valid, so any grant is a handshake
  assign w_take    = |w_grant;
  assign w_sel     = w_grant[1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_take) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (rsp_ready[r_id]) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_id    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_f3    <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_ptr <= w_next_ptr;
        r_id  <= w_sel;
        r_a   <= w_sel ? req_a[2*WIDTH-1:WIDTH]  : req_a[WIDTH-1:0];
        r_b   <= w_sel ? req_b[2*WIDTH-1:WIDTH]  : req_b[WIDTH-1:0];
        r_f3  <= w_sel ? req_funct3[5:3]         : req_funct3[2:0];
      end
    end
  end

  // Compare evaluation on the latched operands
  always_comb begin
    w_flag    = 1'b0;
    w_illegal = 1'b0;
    case (r_f3)
      CMP_EQ:  w_flag = (r_a == r_b);
      CMP_NE:  w_flag = (r_a != r_b);
      CMP_LTU: w_flag = (r_a <  r_b);
      CMP_GEU: w_flag = (r_a >= r_b);
      CMP_GTU: w_flag = (r_a >  r_b);
      CMP_LEU: w_flag = (r_a <= r_b);
`ifdef CMP_ARB_SIGNED_EN
      CMP_LT:  w_flag = ($signed(r_a) <  $signed(r_b));
      CMP_GE:  w_flag = ($signed(r_a) >= $signed(r_b));
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  // Result registers update only in EXEC and otherwise hold, even across IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (r_state == EXEC) begin
      r_flag    <= w_flag;
      r_illegal <= w_illegal;
    end
  end

  assign rsp_flag    = r_flag;
  assign rsp_illegal = r_illegal;

  always_comb begin
    rsp_valid = '0;
    if (r_state == RESP) begin
      rsp_valid[r_id] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_cmp_arbiter                                            |
// | Purpose  : Scoreboard bench for cmp_arbiter. Stimulus pushes the     |
// |            hand-computed response at each handshake; a monitor pops  |
// |            and compares whenever a response is accepted.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_cmp_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*3-1:0]     req_funct3;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic                  rsp_flag;
  logic                  rsp_illegal;

  cmp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_funct3  (req_funct3),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_flag    (rsp_flag),
    .rsp_illegal (rsp_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic id;
    logic flag;
    logic ill;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic exp_ptr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic v);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_funct3[id*3 +: 3]    = f3;
    req_valid[id]            = v;
  endtask

  // Waits (bounded) for a grant, checks it, and records the expected response
  task automatic do_grant(input logic id_exp, input bit push, input logic ef, input logic ei);
    int k = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      fail_now("grant_wait");
    end else begin
      check("grant", {30'd0, req_ready}, id_exp ? 32'd2 : 32'd1);
      if (push) sb.push_back('{id: id_exp, flag: ef, ill: ei});
      exp_ptr = ~id_exp;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      fail_now("drain");
      sb.delete();
    end
  endtask

  // Monitor: compare each accepted response against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && ((rsp_valid & rsp_ready) != 2'b00)) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rsp: rsp_valid=%b flag=%b at %0t", rsp_valid, rsp_flag, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_valid", {30'd0, rsp_valid}, e.id ? 32'd2 : 32'd1);
        check("rsp_flag", {31'd0, rsp_flag}, {31'd0, e.flag});
        check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, e.ill});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [2:0]  bnd_f3 [4] = '{3'b010, 3'b011, 3'b100, 3'b101};
  logic        bnd_fl [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_funct3 = '0;
    rsp_ready = 2'b11;

    // ---- reset state ----
    set_req(0, 32'd3, 32'd3, 3'b000, 1'b1);
    set_req(1, 32'd2, 32'd9, 3'b100, 1'b1);
    @(negedge clk);
    check("ready_in_reset", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("rsp_valid_reset", {30'd0, rsp_valid}, 32'd0);
    check("flag_reset", {31'd0, rsp_flag}, 32'd0);
    check("illegal_reset", {31'd0, rsp_illegal}, 32'd0);

    // ---- contention: both held valid, grants alternate from requester 0 ----
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ptr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_grant(exp_ptr, 1'b1, (exp_ptr == 1'b0), 1'b0);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    drain();

    // ---- single request latency: 5 <u 7 ----
    @(posedge clk); #1;
    set_req(0, 32'd5, 32'd7, 3'b010, 1'b1);
    do_grant(1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("lat_n1_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("lat_n1_ready", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("lat_n2_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    check("lat_n3_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    drain();

    // ---- unsigned boundaries, req0 alone (pointer sits at 1) ----
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      set_req(0, 32'd0, 32'hFFFF_FFFF, bnd_f3[i], 1'b1);
      do_grant(1'b0, 1'b1, bnd_fl[i], 1'b0);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      drain();
    end

    // ---- illegal / signed codes ----
    @(posedge clk); #1;
    set_req(0, 32'hFFFF_FFFF, 32'd1, 3'b110, 1'b1);
`ifdef CMP_ARB_SIGNED_EN
    do_grant(1'b0, 1'b1, 1'b1, 1'b0);
`else
    do_grant(1'b0, 1'b1, 1'b0, 1'b1);
`endif
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    drain();
    @(posedge clk); #1;
    set_req(1, 32'hFFFF_FFFF, 32'd1, 3'b111, 1'b1);
`ifdef CMP_ARB_SIGNED_EN
    do_grant(1'b1, 1'b1, 1'b0, 1'b0);
`else
    do_grant(1'b1, 1'b1, 1'b0, 1'b1);
`endif
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drain();

    // ---- backpressure on requester 1, requester 0 waiting ----
    @(posedge clk); #1;
    rsp_ready = 2'b01;
    set_req(1, 32'd1, 32'd2, 3'b001, 1'b1);
    do_grant(1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_req(0, 32'd3, 32'd3, 3'b000, 1'b1);
    begin
      int k = 0;
      @(negedge clk);
      while (rsp_valid == 2'b00 && k < 10) begin
        @(negedge clk);
        k++;
      end
      if (k >= 10) fail_now("bp_rsp_wait");
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", {30'd0, rsp_valid}, 32'd2);
      check("bp_flag", {31'd0, rsp_flag}, 32'd1);
      check("bp_ready", {30'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      rsp_ready[0] = ~rsp_ready[0];
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    do_grant(1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    drain();

    // ---- reset during EXEC discards the transaction and clears the pointer ----
    @(posedge clk); #1;
    set_req(0, 32'd8, 32'd8, 3'b000, 1'b1);
    do_grant(1'b0, 1'b0, 1'b0, 1'b0);  // pointer now 1, no response expected
    @(posedge clk); #1;
    req_valid = 2'b11;
    set_req(0, 32'd4, 32'd4, 3'b001, 1'b1);
    set_req(1, 32'd6, 32'd5, 3'b100, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ready_mid_reset", {30'd0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
    exp_ptr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    end
    check("post_reset_flag", {31'd0, rsp_flag}, 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b11;  // 4 != 4 -> 0 for req0 ; 6 >u 5 -> 1 for req1
    do_grant(1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    do_grant(1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
